// File: rtl/bcd_stopwatch_counter.sv
// bcd_stopwatch_counter: 4-digit BCD up/down stopwatch with synchronised start/stop toggle,
// load/clear, and a one-cycle wrap pulse.
module bcd_stopwatch_counter #(
    parameter int TICK_DIV = 50000000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start_stop,
    input  logic        clear,
    input  logic        up_down,
    input  logic        load,
    input  logic [15:0] load_value,
    output logic [3:0]  digit0,
    output logic [3:0]  digit1,
    output logic [3:0]  digit2,
    output logic [3:0]  digit3,
    output logic [1:0]  state,
    output logic        wrap
);
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, HOLD = 2'b10} state_t;

    state_t        st;
    logic [PW-1:0] pre;
    logic [15:0]   cnt;
    logic [15:0]   nxt;
    logic          carry;
    logic          sync1, sync2, hist, armed;
    logic [1:0]    valid;
    logic          ss_rise, step;

    function automatic logic [3:0] sat(input logic [3:0] n);
        return (n > 4'd9) ? 4'd9 : n;
    endfunction

    // armed stays low until a genuine low level has passed the synchroniser,
    // so a button held across reset release is not seen as a new press
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            hist  <= 1'b0;
            valid <= 2'b00;
            armed <= 1'b0;
        end else begin
            sync1 <= start_stop;
            sync2 <= sync1;
            hist  <= sync2;
            valid <= {valid[0], 1'b1};
            armed <= armed | (valid[1] & ~sync2);
        end
    end

    assign ss_rise = sync2 & ~hist & armed;
    assign step    = (st == RUN) && (pre == LAST) && !clear && !load && !ss_rise;

    always_comb begin
        nxt   = cnt;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            logic [3:0] dg;
            dg = cnt[i*4 +: 4];
            nxt[i*4 +: 4] = !carry ? dg :
                            up_down ? ((dg == 4'd9) ? 4'd0 : dg + 4'd1) :
                                      ((dg == 4'd0) ? 4'd9 : dg - 4'd1);
            carry = carry & (up_down ? (dg == 4'd9) : (dg == 4'd0));
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            st   <= IDLE;
            pre  <= '0;
            cnt  <= '0;
            wrap <= 1'b0;
        end else begin
            wrap <= step & carry;
            pre  <= (st == RUN && !clear && !load && !ss_rise && pre != LAST) ? pre + PW'(1) : '0;
            if (clear) begin
                st  <= IDLE;
                cnt <= '0;
            end else begin
                if (ss_rise)
                    st <= (st == RUN) ? HOLD : RUN;
                if (load)
                    cnt <= {sat(load_value[15:12]), sat(load_value[11:8]),
                            sat(load_value[7:4]), sat(load_value[3:0])};
                else if (step)
                    cnt <= nxt;
            end
        end
    end

    assign digit0 = cnt[3:0];
    assign digit1 = cnt[7:4];
    assign digit2 = cnt[11:8];
    assign digit3 = cnt[15:12];
    assign state  = st;
endmodule

// File: tb/tb_bcd_stopwatch_counter.sv
// tb_bcd_stopwatch_counter: directed vectors and hand-built sequences for the BCD stopwatch
// with TICK_DIV = 4.
module tb_bcd_stopwatch_counter;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start_stop = 1'b0;
    logic        clear = 1'b0;
    logic        up_down = 1'b1;
    logic        load = 1'b0;
    logic [15:0] load_value = 16'h0000;
    logic [3:0]  digit0, digit1, digit2, digit3;
    logic [1:0]  state;
    logic        wrap;
    logic [15:0] digits;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        clr;
        logic        ld;
        logic [15:0] lv;
        logic [15:0] exp_d;
        logic [1:0]  exp_st;
    } vec_t;

    vec_t vecs[7];

    always #5 clk = ~clk;

    bcd_stopwatch_counter #(.TICK_DIV(4)) dut (
        .clk(clk),
        .resetn(resetn),
        .start_stop(start_stop),
        .clear(clear),
        .up_down(up_down),
        .load(load),
        .load_value(load_value),
        .digit0(digit0),
        .digit1(digit1),
        .digit2(digit2),
        .digit3(digit3),
        .state(state),
        .wrap(wrap)
    );

    assign digits = {digit3, digit2, digit1, digit0};

    task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tickn(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        vecs[0] = '{1'b0, 1'b1, 16'h1234, 16'h1234, 2'b00};
        vecs[1] = '{1'b0, 1'b1, 16'hA5F3, 16'h9593, 2'b00};
        vecs[2] = '{1'b0, 1'b0, 16'h7777, 16'h9593, 2'b00};
        vecs[3] = '{1'b0, 1'b1, 16'hFFFF, 16'h9999, 2'b00};
        vecs[4] = '{1'b0, 1'b1, 16'h9A0B, 16'h9909, 2'b00};
        vecs[5] = '{1'b0, 1'b1, 16'h0999, 16'h0999, 2'b00};
        vecs[6] = '{1'b1, 1'b1, 16'h5555, 16'h0000, 2'b00};

        #2;
        chk("rst_digits", digits, 16'h0000);
        chk("rst_state", 16'(state), 16'h0000);
        chk("rst_wrap", 16'(wrap), 16'h0000);
        tickn(2);
        resetn = 1'b1;
        tickn(4);

        for (int v = 0; v < 7; v++) begin
            clear = vecs[v].clr;
            load = vecs[v].ld;
            load_value = vecs[v].lv;
            tick();
            clear = 1'b0;
            load = 1'b0;
            chk($sformatf("vec%0d_digits", v), digits, vecs[v].exp_d);
            chk($sformatf("vec%0d_state", v), 16'(state), 16'(vecs[v].exp_st));
            chk($sformatf("vec%0d_wrap", v), 16'(wrap), 16'h0000);
        end

        // start: state changes on the 3rd edge, then one step every 4 edges
        up_down = 1'b1;
        start_stop = 1'b1;
        tick();
        chk("start_e1", 16'(state), 16'h0000);
        tick();
        chk("start_e2", 16'(state), 16'h0000);
        tick();
        chk("start_e3", 16'(state), 16'h0001);
        start_stop = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            if (k == 11) start_stop = 1'b1;
            tick();
            chk($sformatf("count_up_k%0d", k), digits, 16'(k / 4));
        end
        tick();
        chk("to_hold_state", 16'(state), 16'h0002);
        chk("to_hold_digits", digits, 16'h0003);
        start_stop = 1'b0;
        tickn(6);
        chk("hold_state", 16'(state), 16'h0002);
        chk("hold_digits", digits, 16'h0003);

        // carry ripple 0999 -> 1000
        load = 1'b1;
        load_value = 16'h0999;
        tick();
        load = 1'b0;
        chk("ld_hold_digits", digits, 16'h0999);
        chk("ld_hold_state", 16'(state), 16'h0002);
        start_stop = 1'b1;
        tickn(2);
        chk("resume_e2", 16'(state), 16'h0002);
        tick();
        chk("resume_e3", 16'(state), 16'h0001);
        start_stop = 1'b0;
        tickn(3);
        chk("ripple_pre", digits, 16'h0999);
        tick();
        chk("ripple_digits", digits, 16'h1000);
        chk("ripple_wrap", 16'(wrap), 16'h0000);

        // wrap up 9999 -> 0000
        load = 1'b1;
        load_value = 16'h9999;
        tick();
        load = 1'b0;
        tickn(3);
        chk("wrap_up_pre", digits, 16'h9999);
        chk("wrap_up_pre_w", 16'(wrap), 16'h0000);
        tick();
        chk("wrap_up_digits", digits, 16'h0000);
        chk("wrap_up_pulse", 16'(wrap), 16'h0001);
        tick();
        chk("wrap_up_after", 16'(wrap), 16'h0000);

        // wrap down 0000 -> 9999, then a plain borrow
        up_down = 1'b0;
        load = 1'b1;
        load_value = 16'h0000;
        tick();
        load = 1'b0;
        tickn(3);
        chk("wrap_dn_pre", digits, 16'h0000);
        tick();
        chk("wrap_dn_digits", digits, 16'h9999);
        chk("wrap_dn_pulse", 16'(wrap), 16'h0001);
        tick();
        chk("wrap_dn_after", 16'(wrap), 16'h0000);
        tickn(3);
        chk("count_down", digits, 16'h9998);

        // direction change takes effect at the next step
        up_down = 1'b1;
        tickn(3);
        chk("dir_pre", digits, 16'h9998);
        tick();
        chk("dir_up", digits, 16'h9999);
        chk("dir_wrap", 16'(wrap), 16'h0000);

        // clear + load on a wrapping step edge
        tickn(3);
        clear = 1'b1;
        load = 1'b1;
        load_value = 16'h1234;
        tick();
        clear = 1'b0;
        load = 1'b0;
        chk("clr_ld_digits", digits, 16'h0000);
        chk("clr_ld_state", 16'(state), 16'h0000);
        chk("clr_ld_wrap", 16'(wrap), 16'h0000);
        tick();
        chk("clr_ld_wrap2", 16'(wrap), 16'h0000);

        // mid-run async reset with start_stop held high
        start_stop = 1'b1;
        tickn(3);
        chk("run2_state", 16'(state), 16'h0001);
        tickn(5);
        chk("run2_digits", digits, 16'h0001);
        resetn = 1'b0;
        #1;
        chk("async_rst_digits", digits, 16'h0000);
        chk("async_rst_state", 16'(state), 16'h0000);
        chk("async_rst_wrap", 16'(wrap), 16'h0000);
        resetn = 1'b1;
        tickn(10);
        chk("held_no_toggle", 16'(state), 16'h0000);
        chk("held_digits", digits, 16'h0000);
        start_stop = 1'b0;
        tickn(3);
        start_stop = 1'b1;
        tickn(2);
        chk("rearm_e2", 16'(state), 16'h0000);
        tick();
        chk("rearm_e3", 16'(state), 16'h0001);
        start_stop = 1'b0;
        tickn(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
